// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared definitions for the CPU bus controller: address map, FSM states,
// region decode and the value returned by unmapped reads.
package cpu_bus_ctrl_pkg;

  // Region bases and limits (RAM always starts at 0x0000).
  localparam logic [15:0] IO_BASE        = 16'h8000;
  localparam logic [15:0] IO_LIMIT       = 16'h80FF;
  localparam logic [15:0] ROM_BASE       = 16'hC000;

  // Byte returned by a read from an unmapped address.
  localparam logic [7:0]  UNMAPPED_RDATA = 8'hFF;

  // Width of the ROM wait-state counter (ROM_WAIT is 0..15).
  localparam int          WAIT_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM,
    S_ROM,
    S_IO,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_ROM,
    REG_NONE
  } region_e;

  // Classify a CPU address. RAM is matched exactly against its size, so
  // addresses just above it fall through to unmapped rather than mirroring.
  function automatic region_e decode_region(input logic [15:0] addr,
                                            input int          ram_aw);
    region_e rgn;
    if ((addr >> ram_aw) == 16'd0) begin
      rgn = REG_RAM;
    end else if (addr >= IO_BASE && addr <= IO_LIMIT) begin
      rgn = REG_IO;
    end else if (addr >= ROM_BASE) begin
      rgn = REG_ROM;
    end else begin
      rgn = REG_NONE;
    end
    return rgn;
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_ram.sv
// Internal zero-page/stack RAM: single port, synchronous write, registered
// read with one cycle of latency.
module bus_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [2**AW];
  logic [7:0] r_rdata;

  // Write port and registered read port sharing one address.
  // NOTE: the array and its read register have no reset so they map onto
  // block RAM; contents therefore survive a controller reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: decodes each CPU request into an internal RAM, external
// ROM (with wait states) or I/O register access, or a bus error, and returns
// completion as a single-cycle cpu_ready pulse with registered read data.
module cpu_bus_ctrl
  import cpu_bus_ctrl_pkg::*;
#(
  parameter int RAM_AW   = 11,
  parameter int ROM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic        bus_err,
  // External ROM port
  output logic [13:0] rom_addr,
  output logic        rom_rd,
  input  logic [7:0]  rom_data,
  // I/O register port
  output logic [7:0]  io_addr,
  output logic        io_re,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata
);

  // FSM state and latched request
  state_e              r_state,    w_state_nxt;
  logic [WAIT_W-1:0]   r_wait,     w_wait_nxt;
  logic                r_we,       w_we_nxt;
  logic [7:0]          r_wdata,    w_wdata_nxt;
  logic [RAM_AW-1:0]   r_ram_addr, w_ram_addr_nxt;

  // Registered outputs
  logic [7:0]          r_rdata,    w_rdata_nxt;
  logic                r_ready,    w_ready_nxt;
  logic                r_err,      w_err_nxt;
  logic                r_rom_rd,   w_rom_rd_nxt;
  logic [13:0]         r_rom_addr, w_rom_addr_nxt;
  logic                r_io_re,    w_io_re_nxt;
  logic                r_io_we,    w_io_we_nxt;
  logic [7:0]          r_io_addr,  w_io_addr_nxt;
  logic [7:0]          r_io_wdata, w_io_wdata_nxt;

  // RAM port
  logic                w_ram_we;
  logic                w_ram_re;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [7:0]          w_ram_rdata;

  region_e             w_region;

  assign w_region = decode_region(cpu_addr, RAM_AW);

  bus_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // State, latched request and output registers; reset aborts any access.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
      r_ram_addr <= '0;
      r_rdata    <= 8'h00;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rom_rd   <= 1'b0;
      r_rom_addr <= 14'h0000;
      r_io_re    <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_addr  <= 8'h00;
      r_io_wdata <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      r_we       <= w_we_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_rdata    <= w_rdata_nxt;
      r_ready    <= w_ready_nxt;
      r_err      <= w_err_nxt;
      r_rom_rd   <= w_rom_rd_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_io_re    <= w_io_re_nxt;
      r_io_we    <= w_io_we_nxt;
      r_io_addr  <= w_io_addr_nxt;
      r_io_wdata <= w_io_wdata_nxt;
    end
  end

  // Next-state decode, RAM port control and next values of the outputs.
  // NOTE: everything assigned here gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_nxt     = r_wait;
    w_we_nxt       = r_we;
    w_wdata_nxt    = r_wdata;
    w_ram_addr_nxt = r_ram_addr;
    w_rdata_nxt    = r_rdata;
    w_ready_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_rom_rd_nxt   = r_rom_rd;
    w_rom_addr_nxt = r_rom_addr;
    w_io_re_nxt    = 1'b0;
    w_io_we_nxt    = 1'b0;
    w_io_addr_nxt  = r_io_addr;
    w_io_wdata_nxt = r_io_wdata;
    w_ram_addr     = r_ram_addr;
    w_ram_we       = 1'b0;
    w_ram_re       = 1'b0;

    case (r_state)
      S_IDLE: begin
        // The RAM is addressed straight from the CPU bus so that its
        // registered read is ready one cycle after acceptance.
        w_ram_addr = cpu_addr[RAM_AW-1:0];
        if (cpu_req) begin
          w_we_nxt       = cpu_we;
          w_wdata_nxt    = cpu_wdata;
          w_ram_addr_nxt = cpu_addr[RAM_AW-1:0];
          case (w_region)
            REG_RAM: begin
              w_state_nxt = S_RAM;
              w_ram_re    = ~cpu_we;
            end
            REG_IO: begin
              w_state_nxt   = S_IO;
              w_io_addr_nxt = cpu_addr[7:0];
              if (cpu_we) begin
                w_io_we_nxt    = 1'b1;
                w_io_wdata_nxt = cpu_wdata;
              end else begin
                w_io_re_nxt    = 1'b1;
              end
            end
            REG_ROM: begin
              if (!cpu_we) begin
                w_state_nxt    = S_ROM;
                w_wait_nxt     = WAIT_W'(ROM_WAIT);
                w_rom_rd_nxt   = 1'b1;
                w_rom_addr_nxt = cpu_addr[13:0];
              end else begin
                w_state_nxt    = S_ERR;
              end
            end
            default: begin
              w_state_nxt = S_ERR;
            end
          endcase
        end
      end

      S_RAM: begin
        // Writes commit at the completing edge; reads take the RAM output.
        if (r_we) begin
          w_ram_we    = 1'b1;
        end else begin
          w_rdata_nxt = w_ram_rdata;
        end
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_ROM: begin
        if (r_wait != '0) begin
          w_wait_nxt   = r_wait - WAIT_W'(1);
        end else begin
          w_rdata_nxt  = rom_data;
          w_ready_nxt  = 1'b1;
          w_rom_rd_nxt = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      end

      S_IO: begin
        if (!r_we) begin
          w_rdata_nxt = io_rdata;
        end
        w_ready_nxt = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_ERR: begin
        if (!r_we) begin
          w_rdata_nxt = UNMAPPED_RDATA;
        end
        w_ready_nxt = 1'b1;
        w_err_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cpu_rdata = r_rdata;
  assign cpu_ready = r_ready;
  assign bus_err   = r_err;
  assign rom_addr  = r_rom_addr;
  assign rom_rd    = r_rom_rd;
  assign io_addr   = r_io_addr;
  assign io_re     = r_io_re;
  assign io_we     = r_io_we;
  assign io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl. A transaction-level model predicts,
// from the address map and latency rules, what every output must be on every
// cycle; directed accesses plus literal expectations pin that model.
module tb_cpu_bus_ctrl;

  localparam int RAM_AW   = 11;
  localparam int ROM_WAIT = 2;
  localparam int RAM_SIZE = 1 << RAM_AW;

  typedef enum int {K_RAM, K_IO, K_ROM, K_ERR} kind_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        bus_err;
  logic [13:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data;
  logic [7:0]  io_addr;
  logic        io_re;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mdl_en = 1'b0;

  // Model of the transaction in flight (cycle numbers count clock edges).
  int          t_acc  = -100;
  int          t_done = -100;
  kind_e       t_kind = K_ERR;
  bit          t_we   = 1'b0;
  logic [15:0] t_addr = 16'h0000;
  logic [7:0]  t_wd   = 8'h00;
  logic [7:0]  t_dev  = 8'h00;
  logic [7:0]  t_old  = 8'h00;
  logic [7:0]  t_new  = 8'h00;
  logic [7:0]  m_rdata = 8'h00;
  logic [7:0]  m_ram [RAM_SIZE];

  // Observed activity, used by the literal expectations.
  int n_ready = 0, n_err = 0, n_rom_rd = 0, n_io_re = 0, n_io_we = 0;
  int last_rdy = -1, prev_rdy = -1;

  cpu_bus_ctrl #(
    .RAM_AW   (RAM_AW),
    .ROM_WAIT (ROM_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .bus_err   (bus_err),
    .rom_addr  (rom_addr),
    .rom_rd    (rom_rd),
    .rom_data  (rom_data),
    .io_addr   (io_addr),
    .io_re     (io_re),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Devices present valid data only in the cycle they must be sampled.
  assign rom_data = (t_kind == K_ROM && cyc == t_done - 1) ? t_dev : 8'hEE;
  assign io_rdata = (t_kind == K_IO  && cyc == t_acc)      ? t_dev : 8'h11;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdata"},    16'(cpu_rdata), 16'h00);
    check({tag, "_ready"},    16'(cpu_ready), 16'h0);
    check({tag, "_err"},      16'(bus_err),   16'h0);
    check({tag, "_rom_rd"},   16'(rom_rd),    16'h0);
    check({tag, "_rom_addr"}, 16'(rom_addr),  16'h0000);
    check({tag, "_io_re"},    16'(io_re),     16'h0);
    check({tag, "_io_we"},    16'(io_we),     16'h0);
    check({tag, "_io_addr"},  16'(io_addr),   16'h00);
    check({tag, "_io_wdata"}, 16'(io_wdata),  16'h00);
  endtask

  // Present a request (call at a negedge) and predict its outcome.
  task automatic start(input bit we, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] dev);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    t_acc  = cyc + 1;
    t_we   = we;
    t_addr = addr;
    t_wd   = wd;
    t_dev  = dev;
    if (int'(addr) < RAM_SIZE)                   t_kind = K_RAM;
    else if (addr >= 16'h8000 && addr <= 16'h80FF) t_kind = K_IO;
    else if (addr >= 16'hC000 && !we)            t_kind = K_ROM;
    else                                         t_kind = K_ERR;
    t_done = t_acc + ((t_kind == K_ROM) ? ROM_WAIT + 1 : 1);
    t_old  = m_rdata;
    if (!we) begin
      case (t_kind)
        K_RAM:   m_rdata = m_ram[addr[RAM_AW-1:0]];
        K_ERR:   m_rdata = 8'hFF;
        default: m_rdata = dev;
      endcase
    end
    t_new = m_rdata;
  endtask

  // Wait (bounded by the predicted latency) until the ready cycle.
  task automatic complete();
    while (cyc < t_done) @(negedge clk);
    if (t_we && t_kind == K_RAM) m_ram[t_addr[RAM_AW-1:0]] = t_wd;
  endtask

  task automatic access(input bit we, input logic [15:0] addr,
                        input logic [7:0] wd, input logic [7:0] dev);
    @(negedge clk);
    start(we, addr, wd, dev);
    complete();
    cpu_req = 1'b0;
  endtask

  // Reset in the first cycle of the access just started.
  task automatic abort_now();
    while (cyc < t_acc) @(negedge clk);
    reset   = 1'b0;
    cpu_req = 1'b0;
    t_acc   = -100;
    t_done  = -100;
    t_kind  = K_ERR;
    t_old   = 8'h00;
    t_new   = 8'h00;
    m_rdata = 8'h00;
    #1;
    check_reset_vals("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_counts();
    n_ready = 0; n_err = 0; n_rom_rd = 0; n_io_re = 0; n_io_we = 0;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mdl_en && reset === 1'b1) begin
        check("ready", 16'(cpu_ready), 16'(cyc == t_done));
        check("bus_err", 16'(bus_err), 16'(cyc == t_done && t_kind == K_ERR));
        check("rdata", 16'(cpu_rdata), 16'((cyc >= t_done) ? t_new : t_old));
        check("rom_rd", 16'(rom_rd),
              16'(t_kind == K_ROM && cyc >= t_acc && cyc < t_done));
        check("io_re", 16'(io_re), 16'(t_kind == K_IO && !t_we && cyc == t_acc));
        check("io_we", 16'(io_we), 16'(t_kind == K_IO && t_we && cyc == t_acc));
        if (rom_rd) check("rom_addr", 16'(rom_addr), 16'(t_addr[13:0]));
        if (io_re || io_we) check("io_addr", 16'(io_addr), 16'(t_addr[7:0]));
        if (io_we) check("io_wdata", 16'(io_wdata), 16'(t_wd));
        if (cpu_ready) begin
          n_ready++;
          prev_rdy = last_rdy;
          last_rdy = cyc;
        end
        if (bus_err) n_err++;
        if (rom_rd)  n_rom_rd++;
        if (io_re)   n_io_re++;
        if (io_we)   n_io_we++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset  = 1'b1;
    mdl_en = 1'b1;

    // RAM write then read back
    clear_counts();
    access(1'b1, 16'h0010, 8'h5A, 8'h00);
    check("ram_wr_lat", 16'(last_rdy - t_acc), 16'd1);
    access(1'b0, 16'h0010, 8'h00, 8'h00);
    check("ram_rd_lat", 16'(last_rdy - t_acc), 16'd1);
    check("ram_rd_val", 16'(cpu_rdata), 16'h5A);
    check("ram_no_err", 16'(n_err), 16'd0);

    // ROM read with wait states
    clear_counts();
    access(1'b0, 16'hFFFC, 8'h00, 8'h34);
    check("rom_val", 16'(cpu_rdata), 16'h34);
    check("rom_rd_cycles", 16'(n_rom_rd), 16'd3);
    check("rom_lat", 16'(last_rdy - t_acc), 16'd3);
    check("rom_addr_held", 16'(rom_addr), 16'h3FFC);

    // I/O write then read
    clear_counts();
    access(1'b1, 16'h8003, 8'h80, 8'h00);
    check("io_we_pulses", 16'(n_io_we), 16'd1);
    check("io_wr_addr", 16'(io_addr), 16'h03);
    check("io_wr_data", 16'(io_wdata), 16'h80);
    access(1'b0, 16'h8005, 8'h00, 8'hC1);
    check("io_re_pulses", 16'(n_io_re), 16'd1);
    check("io_rd_val", 16'(cpu_rdata), 16'hC1);

    // Unmapped read and ROM write
    clear_counts();
    access(1'b0, 16'h4000, 8'h00, 8'h00);
    check("unmap_val", 16'(cpu_rdata), 16'hFF);
    access(1'b0, 16'h0010, 8'h00, 8'h00);
    access(1'b1, 16'hC000, 8'h99, 8'h00);
    check("romwr_err", 16'(n_err), 16'd2);
    check("romwr_keeps_rdata", 16'(cpu_rdata), 16'h5A);
    check("romwr_no_strobe", 16'(n_rom_rd), 16'd0);

    // Region boundaries
    access(1'b1, 16'h07FF, 8'h3C, 8'h00);
    access(1'b0, 16'h07FF, 8'h00, 8'h00);
    check("bnd_07ff", 16'(cpu_rdata), 16'h3C);
    access(1'b0, 16'h0800, 8'h00, 8'h00);
    check("bnd_0800", 16'(cpu_rdata), 16'hFF);
    access(1'b0, 16'h80FF, 8'h00, 8'h9D);
    check("bnd_80ff", 16'(cpu_rdata), 16'h9D);
    access(1'b0, 16'h8100, 8'h00, 8'h00);
    access(1'b0, 16'hBFFF, 8'h00, 8'h00);
    access(1'b0, 16'hC000, 8'h00, 8'h12);
    check("bnd_c000", 16'(cpu_rdata), 16'h12);

    // Back-to-back RAM reads with cpu_req held high
    access(1'b1, 16'h0000, 8'hA1, 8'h00);
    access(1'b1, 16'h0001, 8'hB2, 8'h00);
    @(negedge clk);
    start(1'b0, 16'h0000, 8'h00, 8'h00);
    complete();
    check("b2b_first", 16'(cpu_rdata), 16'hA1);
    start(1'b0, 16'h0001, 8'h00, 8'h00);
    complete();
    cpu_req = 1'b0;
    check("b2b_second", 16'(cpu_rdata), 16'hB2);
    check("b2b_spacing", 16'(last_rdy - prev_rdy), 16'd2);

    // Reset during a ROM wait and during a RAM write
    @(negedge clk);
    start(1'b0, 16'hFFFC, 8'h00, 8'h55);
    abort_now();
    @(negedge clk);
    start(1'b1, 16'h0010, 8'h77, 8'h00);
    abort_now();
    clear_counts();
    access(1'b0, 16'h0010, 8'h00, 8'h00);
    check("rst_ram_kept", 16'(cpu_rdata), 16'h5A);
    check("rst_one_ready", 16'(n_ready), 16'd1);
    access(1'b0, 16'hFFFC, 8'h00, 8'h66);
    check("rst_rom_after", 16'(cpu_rdata), 16'h66);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Memory and I/O bus controller that sits directly upstream of the CPU core. It services each CPU request: it decodes a 16-bit address, performs the RAM, ROM or I/O access, and returns the read byte with a one-cycle ready pulse. It contains the internal zero-page/stack RAM. It also drives an external ROM port with a configurable wait-state count and an 8-bit I/O register port.

## Interface
Parameters:
- RAM_AW, 11: internal RAM address width. RAM occupies 0x0000 to 2^RAM_AW−1.
- ROM_WAIT, 2: extra wait cycles per ROM read. Range 0–15.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- cpu_req, in, 1: request level; sampled only in IDLE.
- cpu_we, in, 1: 1 = write, 0 = read; sampled with cpu_req.
- cpu_addr, in, 16: byte address.
- cpu_wdata, in, 8: write data.
- cpu_rdata, out, 8: read data; registered and held until the next read completes.
- cpu_ready, out, 1: one-cycle completion pulse.
- bus_err, out, 1: one-cycle pulse, coincident with cpu_ready, on an unmapped access or a ROM write.
- rom_addr, out, 14: ROM word address (cpu_addr[13:0]).
- rom_rd, out, 1: ROM read enable, high for the whole ROM access.
- rom_data, in, 8: ROM data, valid by the last wait cycle.
- io_addr, out, 8: I/O register index (cpu_addr[7:0]).
- io_re, io_we, out, 1 each: single-cycle I/O strobes.
- io_wdata, out, 8: I/O write data.
- io_rdata, in, 8: I/O read data, sampled the edge after io_re.

## Operation
Address map:
- RAM: 0x0000 to 2^RAM_AW−1.
- I/O: 0x8000–0x80FF.
- ROM: 0xC000–0xFFFF.
- Everything else is unmapped.

States and transitions:
- IDLE: if cpu_req=1 at an edge, latch addr, we and wdata, then decode:
  - RAM → RAM.
  - I/O → IO.
  - ROM read → ROM; load wait counter with ROM_WAIT.
  - ROM write or unmapped → ERR.
- RAM:
  - Read: RAM is addressed; the next edge captures RAM data into cpu_rdata.
  - Write: the byte commits at the next edge.
  - Either way, set cpu_ready, then → IDLE.
- ROM: rom_rd=1 and rom_addr are driven while in this state.
  - Each edge with counter≠0 decrements the counter.
  - The edge with counter=0 captures rom_data, sets cpu_ready, drops rom_rd, then → IDLE.
- IO: io_re or io_we is high for exactly this one cycle. The next edge captures io_rdata (reads only), sets cpu_ready, then → IDLE.
- ERR: the next edge sets cpu_ready and bus_err.
  - Reads return 0xFF.
  - Writes have no side effect.
  - → IDLE.

Rules:
- cpu_req is ignored outside IDLE.
- A request is never lost or duplicated.
- cpu_rdata is unchanged by writes.
- RAM_AW address bits above the RAM range are compared exactly; there is no mirroring.

## Timing
- Let E0 be the edge that accepts the request. cpu_ready is high in the cycle after:
  - RAM and IO: E1.
  - ERR: E1.
  - ROM: E(ROM_WAIT+1).
- The FSM returns to IDLE on the same edge that raises cpu_ready. If cpu_req is still high at the following edge, that is a new request, giving back-to-back throughput of one access per 2 cycles (RAM/IO).
- The CPU must drop or change cpu_req/cpu_addr during the cycle cpu_ready is high.
- Reset values (async, on reset=0):
  - State IDLE; wait counter 0.
  - cpu_rdata=0x00; cpu_ready, bus_err, rom_rd, io_re, io_we = 0.
  - rom_addr, io_addr, io_wdata = 0.
- Reset mid-transaction aborts it:
  - No cpu_ready is issued.
  - A pending RAM write is not committed.
  - RAM contents are retained and not cleared.
- Address boundaries: 0x07FF is RAM (default RAM_AW); 0x0800 is ERR. 0x80FF is IO; 0x8100 is ERR. 0xBFFF is ERR; 0xC000 is ROM.

## Structure
- A shared `bus_defs.vh` holds:
  - Region base/limit localparams (IO_BASE, IO_LIMIT, ROM_BASE).
  - FSM state encodings.
  - The unmapped-read value 0xFF.
- The CPU core includes the same header for its address constants.
- One sub-module, `bus_ram`: single-port synchronous RAM of 2^RAM_AW × 8, with registered read and 1-cycle latency; no reset on the array.
- The decoder and FSM live in cpu_bus_ctrl.

## Test plan
- Reset, then write 0x5A to 0x0010, then read 0x0010 → cpu_ready after E1 for each access; read returns 0x5A; bus_err=0.
- ROM read of 0xFFFC with ROM_WAIT=2 and rom_data=0x34 → rom_rd high for 3 cycles, rom_addr=0x3FFC; cpu_ready after E3; cpu_rdata=0x34.
- I/O write 0x80 to 0x8003, then read 0x8005 with io_rdata=0xC1 → write: io_we pulses once with io_addr=0x03, io_wdata=0x80; read: io_re pulses once; cpu_rdata=0xC1.
- Read of 0x4000, then write to 0xC000 → read returns 0xFF with bus_err pulse; write gives bus_err pulse; ROM port never strobed.
- Back-to-back RAM reads of 0x0000 and 0x0001 with cpu_req held high → two ready pulses 2 cycles apart, correct data each.
- reset asserted during ROM wait cycle 1, and during a RAM write → no cpu_ready; all outputs at reset values immediately; later read of the RAM address shows old data; next request after reset release is serviced normally.
